// File: rtl/alu_ctrl_pkg.sv
// Shared types and opcodes for the ALU request arbiter and the ALU it feeds.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;

  localparam logic [3:0] ALU_SEL_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SEL_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SEL_SHL  = 4'b0010;
  localparam logic [3:0] ALU_SEL_SHR  = 4'b0011;
  localparam logic [3:0] ALU_SEL_AND  = 4'b0100;
  localparam logic [3:0] ALU_SEL_OR   = 4'b0101;
  localparam logic [3:0] ALU_SEL_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SEL_NAND = 4'b0111;
  localparam logic [3:0] ALU_SEL_NOR  = 4'b1000;
  localparam logic [3:0] ALU_SEL_XNOR = 4'b1001;

endpackage

// File: rtl/alu.sv
// Unclocked ALU shared by the arbiter's requesters.
// CarryOut is always the carry of A+B, independent of the opcode; unknown opcodes give 0.
module alu
  import alu_ctrl_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  logic [8:0] sum;

  assign sum      = {1'b0, A} + {1'b0, B};
  assign CarryOut = sum[8];

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      ALU_SEL_ADD:  ALU_Out = sum[7:0];
      ALU_SEL_SUB:  ALU_Out = A - B;
      ALU_SEL_SHL:  ALU_Out = {A[6:0], 1'b0};
      ALU_SEL_SHR:  ALU_Out = {1'b0, A[7:1]};
      ALU_SEL_AND:  ALU_Out = A & B;
      ALU_SEL_OR:   ALU_Out = A | B;
      ALU_SEL_XOR:  ALU_Out = A ^ B;
      ALU_SEL_NAND: ALU_Out = ~(A & B);
      ALU_SEL_NOR:  ALU_Out = ~(A | B);
      ALU_SEL_XNOR: ALU_Out = ~(A ^ B);
      default:      ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
// Produces nothing while enable is low.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     enable,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N_REQ);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between N_REQ requesters: round-robin grant, registered
// operands onto the ALU, captured result returned with the requester id (accept -> resp in 2 cycles).
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ*SEL_W-1:0]   req_sel,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_carry,
  output logic [$clog2(N_REQ)-1:0] resp_id
);

  localparam int ID_W = $clog2(N_REQ);

  alu_arb_state_t   state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  op_id;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  ptr_next;
  logic [N_REQ-1:0] grant;
  logic             grant_vld;
  logic             arb_en;
  logic [WIDTH-1:0] op_a, op_b, win_a, win_b;
  logic [SEL_W-1:0] op_sel, win_sel;

  // Gated by reset so nothing is handed out in a cycle whose edge wipes it.
  assign arb_en = !reset && ((state == IDLE) || (state == RESP && resp_ready));

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_vld = |grant;
  assign req_ready = grant;
  assign ptr_next  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_a   = req_a[i*WIDTH +: WIDTH];
        win_b   = req_b[i*WIDTH +: WIDTH];
        win_sel = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_id    <= '0;
    end else begin
      if (grant_vld) begin
        op_a   <= win_a;
        op_b   <= win_b;
        op_sel <= win_sel;
        op_id  <= grant_idx;
        rr_ptr <= ptr_next;
      end
      case (state)
        IDLE: if (grant_vld) state <= EXEC;
        EXEC: begin
          resp_data  <= alu_out;
          resp_carry <= alu_carry;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= grant_vld ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed and random checks of alu_req_arbiter driving a real alu, against a
// transaction-level model (pending-result queue plus round-robin pointer).
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [15:0] req_sel = '0;
  logic [3:0]  req_ready;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic        resp_carry;
  logic [1:0]  resp_id;

  always #5 clk = ~clk;

  alu_req_arbiter #(.N_REQ(4), .WIDTH(8), .SEL_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sel(req_sel), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_carry(resp_carry), .resp_id(resp_id)
  );

  alu u_alu (.A(alu_a), .B(alu_b), .ALU_Sel(alu_sel), .ALU_Out(alu_out), .CarryOut(alu_carry));

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         id;
  } resp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // requester-side operands
  logic [7:0] ra[4], rb[4];
  logic [3:0] rs[4];
  logic [3:0] rv = '0;

  // reference model
  resp_t      q[$];
  logic       m_vis = 1'b0;
  logic       m_exec = 1'b0;
  int         m_ptr = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_s = '0;
  int         n_acc = 0, n_resp = 0;
  int         last_grant = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic resp_t ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, input int id);
    resp_t r;
    int    ia = int'(a), ib = int'(b);
    r.c  = (ia + ib) > 255;
    r.id = id;
    case (int'(s))
      0: r.d = 8'((ia + ib) % 256);
      1: r.d = 8'((ia - ib + 256) % 256);
      2: r.d = 8'((ia * 2) % 256);
      3: r.d = 8'(ia / 2);
      4: r.d = a & b;
      5: r.d = a | b;
      6: r.d = a ^ b;
      7: r.d = ~(a & b);
      8: r.d = ~(a | b);
      9: r.d = ~(a ^ b);
      default: r.d = 8'h00;
    endcase
    return r;
  endfunction

  // One clock cycle: drive at negedge, check, advance model across posedge.
  task automatic step();
    int         g;
    logic [3:0] er;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8]   = ra[i];
      req_b[i*8 +: 8]   = rb[i];
      req_sel[i*4 +: 4] = rs[i];
    end
    req_valid = rv;
    #1;
    g = -1;
    if (!reset && !m_exec && (!m_vis || resp_ready))
      for (int k = 0; k < 4; k++)
        if (g < 0 && rv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(m_vis));
    if (m_vis && q.size() > 0) begin
      chk("resp_data", 32'(resp_data), 32'(q[0].d));
      chk("resp_carry", 32'(resp_carry), 32'(q[0].c));
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
    end
    chk("alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({m_a, m_b, m_s}));
    last_grant = g;
    @(posedge clk);
    if (reset) begin
      n_acc  = n_acc - q.size();
      q.delete();
      m_vis  = 1'b0;
      m_exec = 1'b0;
      m_ptr  = 0;
      m_a = '0; m_b = '0; m_s = '0;
    end else begin
      if (m_vis && resp_ready) begin
        void'(q.pop_front());
        m_vis = 1'b0;
        n_resp++;
      end
      if (m_exec) begin
        m_vis  = 1'b1;
        m_exec = 1'b0;
      end
      if (g >= 0) begin
        q.push_back(ref_alu(ra[g], rb[g], rs[g], g));
        m_exec = 1'b1;
        m_ptr  = (g + 1) % 4;
        m_a = ra[g]; m_b = rb[g]; m_s = rs[g];
        n_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic new_op(input int i);
    ra[i] = 8'($urandom);
    rb[i] = 8'($urandom);
    rs[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int         exp_g, ng, found;
    logic [7:0] d0;
    logic       c0;
    logic [1:0] i0;

    for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; rs[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_regs", 32'({resp_data, resp_carry, resp_id}), 32'd0);
    reset = 1'b0;
    step();

    // single op: FF + 01 -> 00 with carry
    ra[0] = 8'hFF; rb[0] = 8'h01; rs[0] = 4'b0000;
    rv = 4'b0001; resp_ready = 1'b1;
    step();
    chk("single_grant", 32'(last_grant), 32'd0);
    rv = 4'b0000;
    step();
    chk("single_vld", 32'(resp_valid), 32'd1);
    chk("single_data", 32'(resp_data), 32'h00);
    chk("single_carry", 32'(resp_carry), 32'd1);
    chk("single_id", 32'(resp_id), 32'd0);
    step();

    // all valid: round-robin, one grant every 2 cycles
    for (int i = 0; i < 4; i++) new_op(i);
    rv = 4'b1111;
    exp_g = 1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (last_grant >= 0) begin
        chk("rr_order", 32'(last_grant), 32'(exp_g));
        exp_g = (exp_g + 1) % 4;
        ng++;
      end
    end
    chk("rr_count", 32'(ng), 32'd8);

    // backpressure held for 5 cycles
    resp_ready = 1'b0;
    chk("bp_vld", 32'(resp_valid), 32'd1);
    d0 = resp_data; c0 = resp_carry; i0 = resp_id;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold", 32'({resp_data, resp_carry, resp_id}), 32'({d0, c0, i0}));
      chk("bp_no_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_release_grant", 32'(last_grant), 32'(exp_g));
    rv = 4'b0000;
    repeat (3) step();

    // wrap: grant req3, then req1 and req3 contend -> req1
    reset = 1'b1; step(); reset = 1'b0;
    rv = 4'b1000;
    step();
    chk("wrap_g3", 32'(last_grant), 32'd3);
    rv = 4'b1010;
    found = -1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (found < 0 && last_grant >= 0) found = last_grant;
    end
    chk("wrap_first", 32'(found), 32'd1);
    rv = 4'b0000;
    repeat (4) step();

    // reset while in EXEC discards the op
    ra[2] = 8'h5A; rb[2] = 8'hC3; rs[2] = 4'b0110;
    rv = 4'b0100;
    step();
    chk("rmo_grant", 32'(last_grant), 32'd2);
    rv = 4'b0000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmo_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmo_req_ready", 32'(req_ready), 32'd0);
    chk("rmo_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    rv = 4'b1111;
    step();
    chk("rmo_next", 32'(last_grant), 32'd0);
    rv = 4'b0000;
    repeat (3) step();

    // random scoreboard
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rv[i] && last_grant == i) begin
          rv[i] = 1'($urandom_range(0, 1));
          if (rv[i]) new_op(i);
        end else if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          new_op(i);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rv = 4'b0000;
    resp_ready = 1'b1;
    repeat (6) step();
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("sb_count", 32'(n_resp), 32'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
